// File: rtl/pll_freq_meter.sv
// pll_freq_meter: counts rising edges of a slow clock derived from the PLL over
// a fixed gate window of the reference clock, reports each window's count and
// overflow, and declares lock after enough consecutive in-tolerance windows.
module pll_freq_meter #(
   parameter int GATE_CYCLES  = 12000,
   parameter int CNT_W        = 16,
   parameter int EXPECTED     = 0,
   parameter int TOL          = 0,
   parameter int LOCK_WINDOWS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             meas_in,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             count_valid,
   output logic             overflow,
   output logic             locked
);

   localparam int                     GATE_W    = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0]      GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam int                     GOOD_W    = $clog2(LOCK_WINDOWS + 1);
   localparam logic [GOOD_W-1:0]      GOOD_MAX  = GOOD_W'(LOCK_WINDOWS);
   localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
   localparam logic signed [CNT_W:0]  EXP_S     = (CNT_W + 1)'(EXPECTED);
   localparam logic [CNT_W:0]         TOL_U     = (CNT_W + 1)'(TOL);

   // Saturating increment of the edge counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic            inc);
      return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

   // |cnt - EXPECTED| <= TOL, evaluated one bit wider so the difference never wraps.
   function automatic logic in_tol(input logic [CNT_W-1:0] cnt);
      logic signed [CNT_W:0] diff;
      logic        [CNT_W:0] mag;
      diff = $signed({1'b0, cnt}) - EXP_S;
      mag  = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
      return (mag <= TOL_U);
   endfunction

   logic                  r_s1, r_s2, r_s3;
   logic [GATE_W-1:0]     r_gate;
   logic [CNT_W-1:0]      r_edge_cnt;
   logic                  r_wovf;
   logic [GOOD_W-1:0]     r_good_n;
   logic [CNT_W-1:0]      r_count;
   logic                  r_valid;
   logic                  r_ovf;
   logic                  r_locked;

   logic                  w_edge;
   logic                  w_term;
   logic [CNT_W-1:0]      w_cnt_next;
   logic                  w_ovf_next;
   logic                  w_good;
   logic [GOOD_W-1:0]     w_good_next;

   assign w_edge      = r_s2 & ~r_s3;
   assign w_term      = (r_gate == GATE_LAST);
   assign w_cnt_next  = sat_inc(r_edge_cnt, w_edge);
   assign w_ovf_next  = r_wovf | (w_edge & (r_edge_cnt == CNT_MAX));
   assign w_good      = ~w_ovf_next & in_tol(w_cnt_next);
   assign w_good_next = !w_good               ? '0 :
                        (r_good_n == GOOD_MAX) ? GOOD_MAX :
                                                 r_good_n + GOOD_W'(1);

   // Synchronizer plus edge-detect flop; runs independently of enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= meas_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // Gate counter: free-running 0..GATE_CYCLES-1 while enabled, parked at 0 otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gate <= '0;
      end else if (!enable || w_term) begin
         r_gate <= '0;
      end else begin
         r_gate <= r_gate + GATE_W'(1);
      end
   end

   // Edge counter and window-overflow flag; cleared at window close so the next window starts at 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_edge_cnt <= '0;
         r_wovf     <= 1'b0;
      end else if (!enable || w_term) begin
         r_edge_cnt <= '0;
         r_wovf     <= 1'b0;
      end else begin
         r_edge_cnt <= w_cnt_next;
         r_wovf     <= w_ovf_next;
      end
   end

   // Window result: count/overflow captured at the terminal cycle, including that cycle's edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (enable && w_term) begin
            r_count <= w_cnt_next;
            r_ovf   <= w_ovf_next;
            r_valid <= 1'b1;
         end
      end
   end

   // Lock tracker: consecutive good windows, saturating; any bad window or disable restarts it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_good_n <= '0;
         r_locked <= 1'b0;
      end else if (!enable) begin
         r_good_n <= '0;
         r_locked <= 1'b0;
      end else if (w_term) begin
         r_good_n <= w_good_next;
         r_locked <= (w_good_next == GOOD_MAX);
      end
   end

   assign count       = r_count;
   assign count_valid = r_valid;
   assign overflow    = r_ovf;
   assign locked      = r_locked;

endmodule
